// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiplier output path: drain FSM states,
// index-width helpers and the default compute latency.
package mm_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DRAIN
   } drain_state_t;

   // Width of an index into n items; a single item still needs one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Cycles from start until the PE network presents a valid result bus.
   function automatic int unsigned default_lat(input int unsigned l2,
                                               input int unsigned x,
                                               input int unsigned y);
      return l2 + x + y + 1;
   endfunction

endpackage

// File: rtl/drain_index_counter.sv
// Row-major (row, col) walker over an X-by-Y result grid, with synchronous
// clear and a flag marking the final element.
module drain_index_counter
   import mm_pkg::*;
#(
   parameter int unsigned X = 4,
   parameter int unsigned Y = 25
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   input  logic                    advance,
   output logic [idx_width(X)-1:0] row,
   output logic [idx_width(Y)-1:0] col,
   output logic                    last
);

   localparam int unsigned RW = idx_width(X);
   localparam int unsigned CW = idx_width(Y);

   logic row_end;
   logic col_end;

   assign row_end = (row == RW'(X - 1));
   assign col_end = (col == CW'(Y - 1));
   assign last    = row_end && col_end;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row <= '0;
         col <= '0;
      end else if (clear) begin
         row <= '0;
         col <= '0;
      end else if (advance) begin
         if (col_end) begin
            col <= '0;
            row <= row_end ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

endmodule

// File: rtl/result_drain.sv
// Output end of the systolic multiplier: waits out the compute latency,
// snapshots the result bus and streams it row-major over valid/ready.
module result_drain
   import mm_pkg::*;
#(
   parameter int unsigned N   = 4,
   parameter int unsigned M   = 11,
   parameter int unsigned X   = 4,
   parameter int unsigned Y   = 25,
   parameter int unsigned L2  = 9,
   parameter int unsigned LAT = default_lat(L2, X, Y)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [X*Y*M-1:0]        data_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [M-1:0]            out_data,
   output logic [idx_width(X)-1:0] out_row,
   output logic [idx_width(Y)-1:0] out_col,
   output logic                    out_last,
   output logic                    busy
);

   localparam int unsigned LW = idx_width(LAT);
   localparam int unsigned FW = idx_width(X * Y);

   // N only keeps the parameter set identical to the loaders that feed the array.
   if (N == 0) begin : g_n_compat
   end

   drain_state_t      state;
   logic [LW-1:0]     lat_cnt;
   logic [X*Y*M-1:0]  snapshot;
   logic [M-1:0]      words [X*Y];
   logic [FW-1:0]     flat;
   logic              idx_clear;
   logic              idx_advance;
   logic              idx_last;

   assign idx_clear   = (state == WAIT) && (lat_cnt == '0);
   assign idx_advance = out_valid && out_ready;

   drain_index_counter #(
      .X (X),
      .Y (Y)
   ) u_index (
      .clk     (clk),
      .rst     (rst),
      .clear   (idx_clear),
      .advance (idx_advance),
      .row     (out_row),
      .col     (out_col),
      .last    (idx_last)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         lat_cnt   <= '0;
         snapshot  <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= WAIT;
                  lat_cnt <= LW'(LAT - 1);
                  busy    <= 1'b1;
               end
            end
            WAIT: begin
               if (lat_cnt == '0) begin
                  snapshot  <= data_in;
                  state     <= DRAIN;
                  out_valid <= 1'b1;
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end
            DRAIN: begin
               if (out_ready && idx_last) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   for (genvar k = 0; k < X * Y; k++) begin : g_words
      assign words[k] = snapshot[k*M +: M];
   end

   assign flat     = FW'(out_row) * FW'(Y) + FW'(out_col);
   assign out_data = words[flat];
   // Indices rest at (0,0) when idle, which is the last element when X=Y=1.
   assign out_last = out_valid && idx_last;

endmodule

// File: tb/tb_result_drain.sv
// Directed scoreboard bench for result_drain with X=2, Y=3, M=11, LAT=15.
module tb_result_drain;

   localparam int unsigned M   = 11;
   localparam int unsigned X   = 2;
   localparam int unsigned Y   = 3;
   localparam int unsigned LAT = 15;

   typedef struct {
      logic [M-1:0] d;
      logic [0:0]   r;
      logic [1:0]   c;
      logic         l;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic [X*Y*M-1:0] data_in = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [M-1:0]     out_data;
   logic [0:0]       out_row;
   logic [1:0]       out_col;
   logic             out_last;
   logic             busy;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   result_drain #(
      .N   (4),
      .M   (M),
      .X   (X),
      .Y   (Y),
      .L2  (9),
      .LAT (LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .data_in   (data_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_row   (out_row),
      .out_col   (out_col),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load_pattern();
      for (int k = 0; k < X * Y; k++) data_in[k*M +: M] = M'(100 + k);
   endtask

   task automatic push_expected();
      exp_t e;
      for (int k = 0; k < X * Y; k++) begin
         e.d = M'(100 + k);
         e.r = 1'(k / Y);
         e.c = 2'(k % Y);
         e.l = (k == X * Y - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, 32'(out_valid), 0);
      check({tag, "_data"},  32'(out_data),  0);
      check({tag, "_row"},   32'(out_row),   0);
      check({tag, "_col"},   32'(out_col),   0);
      check({tag, "_last"},  32'(out_last),  0);
      check({tag, "_busy"},  32'(busy),      0);
   endtask

   // Pulse start at a negedge; returns cycles until out_valid is seen, with
   // an optional extra start pulse after spulse cycles.
   task automatic start_and_wait(input int spulse, output int cyc);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", 32'(busy), 1);
      cyc = 0;
      while (!out_valid && cyc < 100) begin
         start = (cyc == spulse - 1);
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      check("valid_latency", 32'(cyc), LAT);
   endtask

   task automatic drain(input bit bp, input int max_beats, input int spulse, output int got);
      int     pat   = 0;
      int     guard = 0;
      bit     hold  = 0;
      bit     r;
      exp_t   e;
      logic [M-1:0] hd;
      logic [0:0]   hr;
      logic [1:0]   hc;
      logic         hl;
      got = 0;
      while (got < max_beats && guard < 200) begin
         if (hold) begin
            check("hold_valid", 32'(out_valid), 1);
            check("hold_data",  32'(out_data),  32'(hd));
            check("hold_row",   32'(out_row),   32'(hr));
            check("hold_col",   32'(out_col),   32'(hc));
            check("hold_last",  32'(out_last),  32'(hl));
         end
         r = bp ? ((pat % 4) == 0 || (pat % 4) == 3) : 1'b1;
         pat++;
         out_ready = r;
         start = (spulse >= 0 && got == spulse);
         if (out_valid && r) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 32'(got), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("beat_data", 32'(out_data), 32'(e.d));
               check("beat_row",  32'(out_row),  32'(e.r));
               check("beat_col",  32'(out_col),  32'(e.c));
               check("beat_last", 32'(out_last), 32'(e.l));
            end
            got++;
            hold = 0;
         end else if (out_valid) begin
            hold = 1;
            hd = out_data;
            hr = out_row;
            hc = out_col;
            hl = out_last;
         end
         @(negedge clk);
         guard++;
      end
      start = 1'b0;
      out_ready = 1'b0;
      check("drain_timeout", 32'(guard >= 200), 0);
   endtask

   initial begin
      int cyc;
      int got;

      // Reset state
      load_pattern();
      #2;
      check_all_zero("reset_init");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_all_zero("idle");

      // Basic drain
      push_expected();
      start_and_wait(-1, cyc);
      drain(1'b0, X * Y, -1, got);
      check("basic_busy_low", 32'(busy), 0);
      check("basic_valid_low", 32'(out_valid), 0);
      check("basic_queue_empty", 32'(exp_q.size()), 0);

      // Backpressure
      @(negedge clk);
      push_expected();
      start_and_wait(-1, cyc);
      drain(1'b1, X * Y, -1, got);
      check("bp_queue_empty", 32'(exp_q.size()), 0);
      check("bp_busy_low", 32'(busy), 0);

      // Snapshot isolation
      @(negedge clk);
      push_expected();
      start_and_wait(-1, cyc);
      data_in = '1;
      drain(1'b0, X * Y, -1, got);
      check("iso_queue_empty", 32'(exp_q.size()), 0);
      load_pattern();

      // Ignored start: cycle 5 in WAIT, cycle 17 on the third beat of DRAIN
      @(negedge clk);
      push_expected();
      start_and_wait(5, cyc);
      drain(1'b0, X * Y, 2, got);
      check("ign_queue_empty", 32'(exp_q.size()), 0);
      out_ready = 1'b1;
      repeat (20) @(negedge clk);
      check("ign_no_second_stream", 32'(out_valid), 0);
      check("ign_idle", 32'(busy), 0);
      out_ready = 1'b0;

      // Reset mid-drain
      push_expected();
      start_and_wait(-1, cyc);
      drain(1'b0, 3, -1, got);
      #2;
      rst = 1'b0;
      #1;
      check_all_zero("reset_mid_drain");
      exp_q.delete();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      push_expected();
      start_and_wait(-1, cyc);
      drain(1'b0, X * Y, -1, got);
      check("restart_queue_empty", 32'(exp_q.size()), 0);
      check("restart_busy_low", 32'(busy), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
